tt_um_nhcourse_fifo: RTL

TT_UM_NHCOURSE_FIFO -- requirements
Module: tt_um_nhcourse_fifo

---
 rtl/nhcourse_fifo_pkg.sv | 23 ++
 rtl/nhcourse_strobe_sync.sv | 34 +++
 rtl/tt_um_nhcourse_fifo.sv | 119 +++++++++++
 3 files changed

// File: rtl/nhcourse_fifo_pkg.sv
// Shared pin map and defaults for the nhcourse FIFO tile.
// Optional sticky error flags are enabled with NHCOURSE_FIFO_STICKY_EN.
package nhcourse_fifo_pkg;

   localparam int unsigned DEFAULT_DEPTH = 16;

   // uio_in strobe positions
   localparam int unsigned PUSH_BIT = 0;
   localparam int unsigned POP_BIT  = 1;

   // uio_out status positions
   localparam int unsigned FULL_BIT        = 2;
   localparam int unsigned EMPTY_BIT       = 3;
   localparam int unsigned ALMOST_FULL_BIT = 4;
   localparam int unsigned OVERFLOW_BIT    = 5;
   localparam int unsigned UNDERFLOW_BIT   = 6;
   localparam int unsigned VALID_BIT       = 7;

   localparam logic [7:0] UIO_OE_MASK = 8'b1111_1100;

   typedef logic [7:0] data_t;

endpackage

// File: rtl/nhcourse_strobe_sync.sv
// Per-strobe conditioning: either a plain level pass-through or a two-flop
// synchroniser followed by a rising-edge detector producing one-cycle pulses.
module nhcourse_strobe_sync #(
   parameter int unsigned EDGE_MODE = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic strobe_i,
   output logic pulse_o
);

   if (EDGE_MODE != 0) begin : g_edge
      logic [1:0] sync_q;
      logic       hist_q;

      // Synchronous reset; the chain keeps running regardless of the design enable.
      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            sync_q <= 2'b00;
            hist_q <= 1'b0;
         end else begin
            sync_q <= {sync_q[0], strobe_i};
            hist_q <= sync_q[1];
         end
      end

      assign pulse_o = sync_q[1] & ~hist_q;
   end else begin : g_level
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_ni;
      assign pulse_o        = strobe_i;
   end

endmodule

// File: rtl/tt_um_nhcourse_fifo.sv
// First-word fall-through byte FIFO with pin-driven push/pop strobes.
// Define NHCOURSE_FIFO_STICKY_EN to build the sticky overflow/underflow flags.
module tt_um_nhcourse_fifo
   import nhcourse_fifo_pkg::*;
#(
   parameter int unsigned DEPTH     = DEFAULT_DEPTH,
   parameter int unsigned AF_LEVEL  = DEPTH - 2,
   parameter int unsigned EDGE_MODE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
   localparam logic [CntW-1:0] AfCnt   = CntW'(AF_LEVEL);

   logic push_pulse, pop_pulse;

   nhcourse_strobe_sync #(.EDGE_MODE(EDGE_MODE)) u_push_sync (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .strobe_i (uio_in[PUSH_BIT]),
      .pulse_o  (push_pulse)
   );

   nhcourse_strobe_sync #(.EDGE_MODE(EDGE_MODE)) u_pop_sync (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .strobe_i (uio_in[POP_BIT]),
      .pulse_o  (pop_pulse)
   );

   data_t           mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push_req, pop_req, do_push, do_pop;
   logic            full, empty, almost_full, overflow, underflow;

   always_comb begin
      full        = (count_q == FullCnt);
      empty       = (count_q == '0);
      almost_full = (count_q >= AfCnt);
      push_req    = ena & push_pulse;
      pop_req     = ena & pop_pulse;
      do_pop      = pop_req & ~empty;
      // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
      do_push     = push_req & (~full | do_pop);
      wr_ptr_d    = wr_ptr_q + PtrW'(do_push);
      rd_ptr_d    = rd_ptr_q + PtrW'(do_pop);
      count_d     = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= ui_in;
      end
   end

`ifdef NHCOURSE_FIFO_STICKY_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_q | (push_req & ~do_push);
         underflow_q <= underflow_q | (pop_req & ~do_pop);
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

   always_comb begin
      uo_out                   = empty ? 8'h00 : mem_q[rd_ptr_q];
      uio_out                  = 8'h00;
      uio_out[FULL_BIT]        = full;
      uio_out[EMPTY_BIT]       = empty;
      uio_out[ALMOST_FULL_BIT] = almost_full;
      uio_out[OVERFLOW_BIT]    = overflow;
      uio_out[UNDERFLOW_BIT]   = underflow;
      uio_out[VALID_BIT]       = ~empty;
      uio_oe                   = UIO_OE_MASK;
   end

   logic unused_uio;
   assign unused_uio = ^uio_in[7:2];

endmodule
